// File: rtl/ddr_cmd_gen.sv
// DDR command generator: one request at a time, per-bank open-row tracking, PRE/ACT/CAS sequencing.
// Define DDR_AUTOPRE_EN for closed-page operation (RDA/WRA, no explicit PRE); default is open-page.
module ddr_cmd_gen #(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned TRCD      = 4,
    parameter int unsigned TRP       = 4,
    parameter int unsigned TBURST    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 done,
    output logic                 done_hit,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba
);

    localparam int unsigned BKW     = BGWIDTH + BAWIDTH;
    localparam int unsigned NBANK   = 1 << BKW;
    localparam int unsigned TMAX_RC = (TRP > TRCD) ? TRP : TRCD;
    localparam int unsigned TMAX    = (TMAX_RC > TBURST) ? TMAX_RC : TBURST;
    localparam int unsigned CNTW    = $clog2(TMAX + 1);
    localparam int unsigned RAS_BIT = ADDRWIDTH - 1;
    localparam int unsigned CAS_BIT = ADDRWIDTH - 2;
    localparam int unsigned WE_BIT  = ADDRWIDTH - 3;
    localparam int unsigned AP_BIT  = 10;
`ifdef DDR_AUTOPRE_EN
    localparam logic AUTOPRE = 1'b1;
`else
    localparam logic AUTOPRE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_BURST
    } state_t;

    state_t                           state_q, state_d;
    logic [CNTW-1:0]                  cnt_q, cnt_d;
    logic [NBANK-1:0]                 valid_q, valid_d;
    logic [NBANK-1:0][ADDRWIDTH-1:0]  rows_q, rows_d;
    logic                             twr_q, twr_d;
    logic                             hit_q, hit_d;
    logic [BGWIDTH-1:0]               tbg_q, tbg_d;
    logic [BAWIDTH-1:0]               tba_q, tba_d;
    logic [ADDRWIDTH-1:0]             trow_q, trow_d;
    logic [COLWIDTH-1:0]              tcol_q, tcol_d;
    logic                             ready_q, ready_d;
    logic                             done_q, done_d;
    logic                             done_hit_q, done_hit_d;
    logic                             cke_q;
    logic                             cs_n_q, cs_n_d;
    logic                             act_n_q, act_n_d;
    logic [ADDRWIDTH-1:0]             a_q, a_d;
    logic [BGWIDTH-1:0]               bg_q, bg_d;
    logic [BAWIDTH-1:0]               ba_q, ba_d;
    logic [BKW-1:0]                   rbk, tbk;

    assign rbk = {req_bg, req_ba};
    assign tbk = {tbg_q, tba_q};

    // Next-state and next-output logic; every non-command cycle is a deselect.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        rows_d     = rows_q;
        twr_d      = twr_q;
        hit_d      = hit_q;
        tbg_d      = tbg_q;
        tba_d      = tba_q;
        trow_d     = trow_q;
        tcol_d     = tcol_q;
        done_d     = 1'b0;
        done_hit_d = 1'b0;
        cs_n_d     = 1'b1;
        act_n_d    = 1'b1;
        a_d        = '0;
        bg_d       = bg_q;
        ba_d       = ba_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    twr_d  = req_wr;
                    tbg_d  = req_bg;
                    tba_d  = req_ba;
                    trow_d = req_row;
                    tcol_d = req_col;
                    hit_d  = 1'b0;
                    if (valid_q[rbk] && (rows_q[rbk] == req_row)) begin
                        hit_d   = 1'b1;
                        state_d = S_CAS;
                    end else if (valid_q[rbk]) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_ACT;
                    end
                end
            end
            S_PRE: begin
                cs_n_d          = 1'b0;
                a_d[CAS_BIT]    = 1'b1;
                bg_d            = tbg_q;
                ba_d            = tba_q;
                valid_d[tbk]    = 1'b0;
                if (TRP > 1) begin
                    state_d = S_WAIT_RP;
                    cnt_d   = CNTW'(TRP - 2);
                end else begin
                    state_d = S_ACT;
                end
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) begin
                    if (AUTOPRE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACT;
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_ACT: begin
                cs_n_d       = 1'b0;
                act_n_d      = 1'b0;
                a_d          = trow_q;
                bg_d         = tbg_q;
                ba_d         = tba_q;
                valid_d[tbk] = 1'b1;
                rows_d[tbk]  = trow_q;
                if (TRCD > 1) begin
                    state_d = S_WAIT_RCD;
                    cnt_d   = CNTW'(TRCD - 2);
                end else begin
                    state_d = S_CAS;
                end
            end
            S_WAIT_RCD: begin
                if (cnt_q == '0) begin
                    state_d = S_CAS;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_CAS: begin
                cs_n_d                = 1'b0;
                a_d[RAS_BIT]          = 1'b1;
                a_d[WE_BIT]           = ~twr_q;
                a_d[COLWIDTH-1:0]     = tcol_q;
                a_d[AP_BIT]           = AUTOPRE;
                bg_d                  = tbg_q;
                ba_d                  = tba_q;
                if (AUTOPRE) begin
                    valid_d[tbk] = 1'b0;
                end
                state_d = S_WAIT_BURST;
                cnt_d   = CNTW'(TBURST - 1);
            end
            S_WAIT_BURST: begin
                if (cnt_q == '0) begin
                    if (AUTOPRE && (TRP > 1)) begin
                        state_d = S_WAIT_RP;
                        cnt_d   = CNTW'(TRP - 2);
                    end else begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        done_hit_d = hit_q & ~AUTOPRE;
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // All state, table and DRAM-facing outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            rows_q     <= '0;
            twr_q      <= 1'b0;
            hit_q      <= 1'b0;
            tbg_q      <= '0;
            tba_q      <= '0;
            trow_q     <= '0;
            tcol_q     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            done_hit_q <= 1'b0;
            cke_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            act_n_q    <= 1'b1;
            a_q        <= '0;
            bg_q       <= '0;
            ba_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            rows_q     <= rows_d;
            twr_q      <= twr_d;
            hit_q      <= hit_d;
            tbg_q      <= tbg_d;
            tba_q      <= tba_d;
            trow_q     <= trow_d;
            tcol_q     <= tcol_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            done_hit_q <= done_hit_d;
            cke_q      <= 1'b1;
            cs_n_q     <= cs_n_d;
            act_n_q    <= act_n_d;
            a_q        <= a_d;
            bg_q       <= bg_d;
            ba_q       <= ba_d;
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign done_hit  = done_hit_q;
    assign cke       = cke_q;
    assign cs_n      = cs_n_q;
    assign act_n     = act_n_q;
    assign A         = a_q;
    assign bg        = bg_q;
    assign ba        = ba_q;

endmodule
